// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchronizer, per-channel debounce, and press/release/long-press
// pulse generation. Define BTN_AUTOREPEAT_EN to re-pulse btn_press every REPEAT_CYCLES while held.
module button_conditioner #(
  parameter int N_BTN         = 3,
  parameter int DB_CYCLES     = 1000000,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("button_conditioner: illegal DB_CYCLES/LONG_CYCLES/REPEAT_CYCLES combination");
  end

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [N_BTN-1:0]  sync1, sync2;
  logic [N_BTN-1:0]  stable_nxt, press_nxt, release_nxt, long_nxt;
  logic [DB_W-1:0]   db_cnt       [N_BTN];
  logic [DB_W-1:0]   db_cnt_nxt   [N_BTN];
  logic [HOLD_W-1:0] hold_cnt     [N_BTN];
  logic [HOLD_W-1:0] hold_cnt_nxt [N_BTN];
  state_t            state        [N_BTN];
  state_t            state_nxt    [N_BTN];

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0]  rpt_cnt      [N_BTN];
  logic [RPT_W-1:0]  rpt_cnt_nxt  [N_BTN];
`endif

  always_comb begin
    logic rise, fall;
    for (int i = 0; i < N_BTN; i++) begin
      rise            = 1'b0;
      fall            = 1'b0;
      stable_nxt[i]   = btn_level[i];
      db_cnt_nxt[i]   = '0;
      state_nxt[i]    = state[i];
      hold_cnt_nxt[i] = hold_cnt[i];
      press_nxt[i]    = 1'b0;
      release_nxt[i]  = 1'b0;
      long_nxt[i]     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_nxt[i]  = rpt_cnt[i];
`endif

      // Any sample agreeing with the accepted level restarts the stability count.
      if (sync2[i] != btn_level[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_nxt[i] = sync2[i];
          rise          = sync2[i];
          fall          = ~sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + 1'b1;
        end
      end

      unique case (state[i])
        IDLE: begin
          if (rise) begin
            state_nxt[i]    = PRESSED;
            hold_cnt_nxt[i] = '0;
            press_nxt[i]    = 1'b1;
          end
        end
        PRESSED: begin
          // A release on the same cycle the hold would mature wins: no long pulse.
          if (fall) begin
            state_nxt[i]   = IDLE;
            release_nxt[i] = 1'b1;
          end else if (hold_cnt[i] == HOLD_LAST) begin
            state_nxt[i] = HELD;
            long_nxt[i]  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_nxt[i] = '0;
`endif
          end else begin
            hold_cnt_nxt[i] = hold_cnt[i] + 1'b1;
          end
        end
        HELD: begin
          if (fall) begin
            state_nxt[i]   = IDLE;
            release_nxt[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_nxt[i] = '0;
          end else if (rpt_cnt[i] == RPT_LAST) begin
            press_nxt[i]   = 1'b1;
            rpt_cnt_nxt[i] = '0;
          end else begin
            rpt_cnt_nxt[i] = rpt_cnt[i] + 1'b1;
`endif
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
        state[i]    <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
        rpt_cnt[i]  <= '0;
`endif
      end
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      btn_level   <= stable_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_long    <= long_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i]   <= db_cnt_nxt[i];
        hold_cnt[i] <= hold_cnt_nxt[i];
        state[i]    <= state_nxt[i];
`ifdef BTN_AUTOREPEAT_EN
        rpt_cnt[i]  <= rpt_cnt_nxt[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized run-length stimulus, all
// checked against an edge-count reference model. Honors BTN_AUTOREPEAT_EN like the design.
module tb_button_conditioner;
  localparam int N    = 3;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  int vectors     = 0;
  int miscompares = 0;

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples by edge, accepted level flips once the DB samples taken
  // 2..DB+1 edges ago all disagree with it; pulses derive from edge distance to the last rise.
  logic [N-1:0] samp [DB+2];
  logic [N-1:0] m_lvl, m_press, m_rel, m_long;
  int           n;
  int           rise_at [N];

  function automatic void model_reset();
    n = 0;
    for (int k = 0; k < DB + 2; k++) samp[k] = '0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) rise_at[c] = 0;
  endfunction

  function automatic void model_edge();
    logic agree;
    int   held;
    if (!rst) begin
      model_reset();
      return;
    end
    n++;
    for (int k = DB + 1; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = btn_raw;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int c = 0; c < N; c++) begin
      agree = 1'b1;
      for (int k = 2; k <= DB + 1; k++) if (samp[k][c] == m_lvl[c]) agree = 1'b0;
      if (agree) begin
        m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c]) begin
          m_press[c] = 1'b1;
          rise_at[c] = n;
        end else begin
          m_rel[c] = 1'b1;
        end
      end else if (m_lvl[c]) begin
        held = n - rise_at[c];
        if (held == LONG) m_long[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        else if (held > LONG && (held - LONG) % REP == 0) m_press[c] = 1'b1;
`endif
      end
    end
  endfunction

  function automatic logic [4*N-1:0] model_out();
    return {m_lvl, m_press, m_rel, m_long};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [4*N-1:0] got;
    for (int k = 1; k <= 3; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL reset k=%0d: got %b want %b", k, got, 12'b0);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_clean_press();
    logic [4*N-1:0] got, want;
    btn_raw = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      step();
      got  = {btn_level, btn_press, btn_release, btn_long};
      want = {(k >= 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000, 6'b0};
      vectors++;
      if (got !== want || got !== model_out()) begin
        miscompares++;
        $display("FAIL clean_press k=%0d: got %b want %b model %b", k, got, want, model_out());
      end
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (got !== model_out()) begin
        miscompares++;
        $display("FAIL clean_release k=%0d: got %b want %b", k, got, model_out());
      end
    end
  endtask

  task automatic test_bounce();
    logic [4*N-1:0] got;
    logic [11:0]    pat;
    pat = 12'b0000_0110_111;
    for (int k = 0; k < 12; k++) begin
      btn_raw = {1'b0, pat[k], 1'b0};
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (got !== '0 || got !== model_out()) begin
        miscompares++;
        $display("FAIL bounce k=%0d: got %b want %b model %b", k, got, 12'b0, model_out());
      end
    end
  endtask

  task automatic test_long_press();
    logic [4*N-1:0] got;
    logic           found;
    btn_raw = 3'b100;
    found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (got !== model_out()) begin
        miscompares++;
        $display("FAIL long_wait k=%0d: got %b want %b", k, got, model_out());
      end
      if (btn_press[2]) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL long_press_seen: got 0 want 1 within 10 cycles");
    end
    for (int k = 1; k <= 25; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (btn_long !== ((k == LONG) ? 3'b100 : 3'b000) || got !== model_out()) begin
        miscompares++;
        $display("FAIL long_pulse k=%0d: got %b want long=%b model %b", k, got,
                 (k == LONG) ? 3'b100 : 3'b000, model_out());
      end
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (btn_release !== ((k == 6) ? 3'b100 : 3'b000) || got !== model_out()) begin
        miscompares++;
        $display("FAIL long_release k=%0d: got %b want rel=%b model %b", k, got,
                 (k == 6) ? 3'b100 : 3'b000, model_out());
      end
    end
    for (int k = 1; k <= 30; k++) begin
      btn_raw = (k <= 10) ? 3'b100 : 3'b000;
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (btn_long !== 3'b000 || got !== model_out()) begin
        miscompares++;
        $display("FAIL short_hold k=%0d: got %b want long=000 model %b", k, got, model_out());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4*N-1:0] got;
    btn_raw = 3'b101;
    for (int k = 1; k <= 12; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (btn_press !== ((k == 6) ? 3'b101 : 3'b000) || got !== model_out()) begin
        miscompares++;
        $display("FAIL simul_press k=%0d: got %b want press=%b model %b", k, got,
                 (k == 6) ? 3'b101 : 3'b000, model_out());
      end
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (btn_release !== ((k == 6) ? 3'b101 : 3'b000) || got !== model_out()) begin
        miscompares++;
        $display("FAIL simul_release k=%0d: got %b want rel=%b model %b", k, got,
                 (k == 6) ? 3'b101 : 3'b000, model_out());
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4*N-1:0] got;
    btn_raw = 3'b001;
    for (int k = 1; k <= 8; k++) step();
    vectors++;
    if (btn_level !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_hold_level: got %b want %b", btn_level, 3'b001);
    end
    rst = 1'b0;
    model_reset();
    #1;
    got = {btn_level, btn_press, btn_release, btn_long};
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", got, 12'b0);
    end
    for (int k = 1; k <= 2; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL in_reset k=%0d: got %b want %b", k, got, 12'b0);
      end
    end
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (btn_press !== ((k == 6) ? 3'b001 : 3'b000) || got !== model_out()) begin
        miscompares++;
        $display("FAIL post_reset_press k=%0d: got %b want press=%b model %b", k, got,
                 (k == 6) ? 3'b001 : 3'b000, model_out());
      end
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 10; k++) step();
  endtask

  task automatic test_autorepeat();
    logic [4*N-1:0] got;
    logic [N-1:0]   exp_p;
    logic           found;
    btn_raw = 3'b001;
    found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      step();
      if (btn_press[0]) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL repeat_press_seen: got 0 want 1 within 10 cycles");
    end
    for (int k = 1; k <= 42; k++) begin
      step();
`ifdef BTN_AUTOREPEAT_EN
      exp_p = (k > LONG && (k % REP) == 0) ? 3'b001 : 3'b000;
`else
      exp_p = 3'b000;
`endif
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if ({btn_press, btn_long} !== {exp_p, (k == LONG) ? 3'b001 : 3'b000} || got !== model_out()) begin
        miscompares++;
        $display("FAIL autorepeat k=%0d: got %b want press=%b long=%b model %b", k, got, exp_p,
                 (k == LONG) ? 3'b001 : 3'b000, model_out());
      end
    end
    btn_raw = 3'b000;
    for (int k = 1; k <= 10; k++) step();
  endtask

  task automatic test_random();
    logic [4*N-1:0] got;
    int             run [N];
    for (int c = 0; c < N; c++) run[c] = $urandom_range(1, 30);
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < N; c++) begin
        run[c]--;
        if (run[c] <= 0) begin
          btn_raw[c] = ~btn_raw[c];
          run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
        end
      end
      step();
      got = {btn_level, btn_press, btn_release, btn_long};
      vectors++;
      if (got !== model_out()) begin
        miscompares++;
        $display("FAIL random t=%0d raw=%b: got %b want %b", t, btn_raw, got, model_out());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    btn_raw = '0;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    test_autorepeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
